// File: rtl/count_decoder_pkg.sv
// Shared types and constants for count_decoder.
//   op_t    : step classification reported on the op port
//   state_t : direction-tracking FSM states
package count_decoder_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        INC  = 2'd1,
        DEC  = 2'd2,
        LOAD = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        NEUTRAL = 2'd1,
        UP      = 2'd2,
        DOWN    = 2'd3
    } state_t;

    localparam logic [7:0]  RUN_LEN_MAX = 8'hFF;
    localparam logic [15:0] STAT_MAX    = 16'hFFFF;

    // Saturating increment of a 16-bit statistics counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == STAT_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/count_step_classify.sv
// Combinational classifier for one counter step.
// Ports:
//   prev : previously sampled counter value (N bits)
//   cur  : newly sampled counter value (N bits)
//   op   : HOLD / INC / DEC / LOAD
//   wrap : step crossed the modulo-2^N boundary (INC or DEC only)
module count_step_classify
    import count_decoder_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] prev,
    input  logic [N-1:0] cur,
    output op_t          op,
    output logic         wrap
);

    localparam logic [N-1:0] ONE = N'(1);

    logic [N-1:0] prev_inc;
    logic [N-1:0] prev_dec;

    // Modulo arithmetic falls out of the N-bit truncation.
    assign prev_inc = prev + ONE;
    assign prev_dec = prev - ONE;

    always_comb begin
        op   = LOAD;
        wrap = 1'b0;
        if (cur == prev) begin
            op = HOLD;
        end else if (cur == prev_inc) begin
            op   = INC;
            wrap = (prev == '1);
        end else if (cur == prev_dec) begin
            op   = DEC;
            wrap = (prev == '0);
        end
    end

endmodule

// File: rtl/count_decoder.sv
// Decodes the sampled output of a loadable up/down counter into step events.
// Optional feature macro: COUNT_DECODER_STATS_EN adds per-op event counters.
// Ports:
//   clk      : clock, rising edge
//   R        : asynchronous active-low reset
//   en       : sample strobe, Q_in consumed only when high
//   Q_in     : observed counter value (N bits)
//   op       : class of last sampled step (HOLD=0, INC=1, DEC=2, LOAD=3)
//   op_valid : one-cycle pulse qualifying op / wrap / dir_chg
//   wrap     : step crossed the modulo boundary
//   dir_chg  : step reversed the remembered direction
//   run_len  : consecutive identical op count, saturating at 255
//   last_q   : most recently sampled Q_in
//   inc_cnt, dec_cnt, load_cnt : (stats build only) saturating 16-bit op counters
module count_decoder
    import count_decoder_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         R,
    input  logic         en,
    input  logic [N-1:0] Q_in,
    output logic [1:0]   op,
    output logic         op_valid,
    output logic         wrap,
    output logic         dir_chg,
    output logic [7:0]   run_len,
    output logic [N-1:0] last_q
`ifdef COUNT_DECODER_STATS_EN
    ,
    output logic [15:0]  inc_cnt,
    output logic [15:0]  dec_cnt,
    output logic [15:0]  load_cnt
`endif
);

    state_t state_q;
    op_t    step_op;
    logic   step_wrap;
    logic   step_live;

    count_step_classify #(
        .N (N)
    ) u_classify (
        .prev (last_q),
        .cur  (Q_in),
        .op   (step_op),
        .wrap (step_wrap)
    );

    // A sample only yields an op once a prior sample exists.
    assign step_live = en && (state_q != EMPTY);

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state_q  <= EMPTY;
            op       <= HOLD;
            op_valid <= 1'b0;
            wrap     <= 1'b0;
            dir_chg  <= 1'b0;
            run_len  <= 8'd0;
            last_q   <= '0;
        end else begin
            op_valid <= 1'b0;
            if (en) begin
                last_q <= Q_in;
            end
            if (en && state_q == EMPTY) begin
                state_q <= NEUTRAL;
            end else if (step_live) begin
                op_valid <= 1'b1;
                op       <= step_op;
                wrap     <= step_wrap;
                dir_chg  <= (step_op == INC && state_q == DOWN) ||
                            (step_op == DEC && state_q == UP);
                // op still holds the previous valid op (HOLD straight after reset).
                if (step_op != op_t'(op)) begin
                    run_len <= 8'd1;
                end else if (run_len != RUN_LEN_MAX) begin
                    run_len <= run_len + 8'd1;
                end
                unique case (step_op)
                    INC:     state_q <= UP;
                    DEC:     state_q <= DOWN;
                    LOAD:    state_q <= NEUTRAL;
                    default: state_q <= state_q;
                endcase
            end
        end
    end

`ifdef COUNT_DECODER_STATS_EN
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            inc_cnt  <= 16'd0;
            dec_cnt  <= 16'd0;
            load_cnt <= 16'd0;
        end else if (step_live) begin
            if (step_op == INC)  inc_cnt  <= sat_inc16(inc_cnt);
            if (step_op == DEC)  dec_cnt  <= sat_inc16(dec_cnt);
            if (step_op == LOAD) load_cnt <= sat_inc16(load_cnt);
        end
    end
`endif

endmodule

// File: doc/count_decoder.md
COUNT_DECODER -- requirements
Module: count_decoder

Interface
REQ-001 SHALL have parameter N, default 4, sample width of the observed counter value (N >= 2).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port R  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port en  input  1  sample strobe; Q_in is consumed only when en=1.
REQ-005 SHALL have port Q_in  input  N  observed output of a loadable up/down counter.
REQ-006 SHALL have port op  output  2  classification of the last sampled step (HOLD=0, INC=1, DEC=2, LOAD=3).
REQ-007 SHALL have port op_valid  output  1  one-cycle pulse qualifying op, wrap, dir_chg.
REQ-008 SHALL have port wrap  output  1  step crossed the modulo boundary.
REQ-009 SHALL have port dir_chg  output  1  step reversed the remembered count direction.
REQ-010 SHALL have port run_len  output  8  consecutive identical op count, saturating.
REQ-011 SHALL have port last_q  output  N  most recently sampled Q_in.

Function
REQ-012 SHALL classify each sample against the previous sample: equal -> HOLD; prev+1 mod 2^N -> INC; prev-1 mod 2^N -> DEC; any other value -> LOAD.
REQ-013 SHALL assert wrap with INC from 2^N-1 to 0 and with DEC from 0 to 2^N-1; wrap=0 for HOLD and LOAD.
REQ-014 SHALL register op, wrap, dir_chg, op_valid: outputs valid the cycle after the en=1 edge that captured the second of two samples (latency 1).
REQ-015 SHALL keep FSM states EMPTY (no prior sample), NEUTRAL (prior sample, no direction), UP, DOWN.
REQ-016 SHALL transition EMPTY -> NEUTRAL on first en=1, capturing last_q, with op_valid=0.
REQ-017 SHALL transition from NEUTRAL/UP/DOWN on en=1: INC -> UP, DEC -> DOWN, LOAD -> NEUTRAL, HOLD -> unchanged.
REQ-018 SHALL pulse dir_chg only for INC in state DOWN or DEC in state UP; never after LOAD, never on HOLD.
REQ-019 SHALL set run_len=1 when op differs from the previous valid op, else increment, saturating at 255.
REQ-020 SHALL hold all state and outputs (op_valid=0) when en=0; gaps in en do not break a run.
REQ-021 SHALL update last_q on every en=1 sample, including the first.

Reset
REQ-022 SHALL, while R=0, immediately force state EMPTY, op=HOLD, op_valid=0, wrap=0, dir_chg=0, run_len=0, last_q=0.
REQ-023 SHALL treat the first en=1 sample after reset release (including mid-stream reset) as a priming sample only, producing no op_valid.

Configuration
REQ-024 SHALL, when COUNT_DECODER_STATS_EN is defined, add outputs inc_cnt, dec_cnt, load_cnt (16 bits each, saturating at 65535, cleared by R) incrementing on each corresponding op_valid.
REQ-025 SHALL, when COUNT_DECODER_STATS_EN is undefined, omit those ports and counters entirely; all other behaviour is identical.

Structure
REQ-026 SHALL place op_t enum (HOLD, INC, DEC, LOAD) and state_t enum (EMPTY, NEUTRAL, UP, DOWN) in package count_decoder_pkg.
REQ-027 SHALL implement the combinational step classifier (prev, cur -> op, wrap) as sub-module count_step_classify.

Verification
REQ-028 SHALL check: reset, en=1 with Q_in 3,4,5 -> no pulse for 3; op=INC twice, run_len 1 then 2, wrap=0.
REQ-029 SHALL check: Q_in 14,15,0,1 (N=4) -> INC x3, wrap=1 only on 15->0, run_len reaches 3.
REQ-030 SHALL check: Q_in 6,7,7,6 -> INC, HOLD (run_len=1), DEC with dir_chg=1.
REQ-031 SHALL check: Q_in 5,6,12,11 -> INC, LOAD (wrap=0), DEC with dir_chg=0.
REQ-032 SHALL check: Q_in 0,15 -> DEC with wrap=1; then R pulsed low mid-stream -> outputs zero asynchronously, next sample 9 gives no op_valid.
REQ-033 SHALL check with COUNT_DECODER_STATS_EN: 300 consecutive INC samples -> run_len saturates at 255, inc_cnt=299.
